// File: rtl/mux_rr_arbiter_pkg.sv
// rtl/mux_rr_arbiter_pkg.sv - shared types and constants for the round-robin mux arbiter
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } arb_state_t;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [N_REQ-1:0] req_t;

    // Result of one round-robin search: winning index and whether anyone asked
    typedef struct packed {
        logic found;
        sel_t idx;
    } rr_pick_t;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - requester/sink bundle for the round-robin mux arbiter
interface mux_rr_arbiter_if #(
    parameter int DATA_W = 8
);
    import mux_arb_pkg::*;

    req_t              req;
    logic [DATA_W-1:0] din0;
    logic [DATA_W-1:0] din1;
    logic [DATA_W-1:0] din2;
    logic [DATA_W-1:0] din3;
    req_t              gnt;
    sel_t              sel;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    // Arbiter side
    modport slave (
        input  req, din0, din1, din2, din3, out_ready,
        output gnt, sel, out_valid, out_data
    );

    // Producers plus sink side
    modport master (
        output req, din0, din1, din2, din3, out_ready,
        input  gnt, sel, out_valid, out_data
    );

endinterface

// File: rtl/mux_rr_arbiter_mux4.sv
// rtl/mux_rr_arbiter_mux4.sv - combinational 4:1 data mux shared by the requesters
module mux4
    import mux_arb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic [DATA_W-1:0] din2,
    input  logic [DATA_W-1:0] din3,
    input  sel_t              sel,
    output logic [DATA_W-1:0] dout
);

    // Pure select; the arbiter registers the result
    always_comb begin
        dout = din0;
        case (sel)
            2'd0:    dout = din0;
            2'd1:    dout = din1;
            2'd2:    dout = din2;
            default: dout = din3;
        endcase
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter driving a shared 4:1 mux into a valid/ready output register
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit ASSERT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    mux_rr_arbiter_if.slave  bus
);

    // First requester at or after ptr, wrapping 3 -> 0; descending scan so the
    // smallest offset from ptr is the last (winning) assignment
    function automatic rr_pick_t rr_pick(input req_t req, input sel_t ptr);
        rr_pick_t r;
        sel_t     idx;
        r.found = 1'b0;
        r.idx   = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + sel_t'(k);
            if (req[idx]) begin
                r.found = 1'b1;
                r.idx   = idx;
            end
        end
        return r;
    endfunction

    arb_state_t        state_q, state_d;
    logic [DATA_W-1:0] data_q,  data_d;
    sel_t              sel_q,   sel_d;
    sel_t              ptr_q,   ptr_d;

    rr_pick_t          pick;
    logic              load;
    req_t              gnt_c;
    logic [DATA_W-1:0] mux_out;

    // Winner search and load decision; a reset cycle never grants
    always_comb begin
        pick = rr_pick(bus.req, ptr_q);
        load = !rst && pick.found && (state_q == IDLE || bus.out_ready);
    end

    mux4 #(
        .DATA_W (DATA_W)
    ) u_mux (
        .din0 (bus.din0),
        .din1 (bus.din1),
        .din2 (bus.din2),
        .din3 (bus.din3),
        .sel  (pick.idx),
        .dout (mux_out)
    );

    // Next-state, capture and grant generation
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        gnt_c   = '0;

        if (load) begin
            gnt_c[pick.idx] = 1'b1;
            data_d          = mux_out;
            sel_d           = pick.idx;
            ptr_d           = pick.idx + sel_t'(1);
        end

        case (state_q)
            IDLE: begin
                if (load) state_d = FULL;
            end
            FULL: begin
                if (bus.out_ready && !load) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any held word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.sel       = sel_q;
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;

    if (ASSERT_EN) begin : g_assert
        logic              chk_vld_q,  chk_vld_d;
        logic [DATA_W-1:0] chk_data_q, chk_data_d;

        // Independent pick of the winning input, bypassing mux4, as reference
        always_comb begin
            chk_vld_d  = load;
            chk_data_d = chk_data_q;
            if (load) begin
                case (pick.idx)
                    2'd0:    chk_data_d = bus.din0;
                    2'd1:    chk_data_d = bus.din1;
                    2'd2:    chk_data_d = bus.din2;
                    default: chk_data_d = bus.din3;
                endcase
            end
        end

        // Remember what should have been captured at the last load edge
        always_ff @(posedge clk) begin
            if (rst) begin
                chk_vld_q  <= 1'b0;
                chk_data_q <= '0;
            end else begin
                chk_vld_q  <= chk_vld_d;
                chk_data_q <= chk_data_d;
            end
        end

        // Grant/select/data consistency checks
        always_comb begin
            a_gnt_onehot: assert ($onehot0(gnt_c))
                else $error("%0t gnt not onehot0: %b", $time, gnt_c);
            a_gnt_req: assert ((gnt_c & ~bus.req) == '0)
                else $error("%0t gnt without req: gnt=%b req=%b", $time, gnt_c, bus.req);
            a_valid_state: assert (bus.out_valid == (state_q == FULL))
                else $error("%0t out_valid disagrees with state", $time);
            a_capture: assert (!chk_vld_q || data_q == chk_data_q)
                else $error("%0t out_data %h != din_sel %h", $time, data_q, chk_data_q);
        end
    end

endmodule
